// File: rtl/expl_axi_if.sv
// AXI bus bundle between the expl_axi master port and its SRAM responder.
interface expl_axi_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              arvalid;
    logic              arready;
    logic [ADDR_W-1:0] araddr;
    logic [1:0]        arburst;
    logic [3:0]        arlen;
    logic [2:0]        arsize;
    logic [3:0]        arcache;
    logic [2:0]        arprot;
    logic [1:0]        arlock;

    logic              awvalid;
    logic              awready;
    logic [ADDR_W-1:0] awaddr;
    logic [1:0]        awburst;
    logic [3:0]        awlen;
    logic [2:0]        awsize;
    logic [3:0]        awcache;
    logic [2:0]        awprot;
    logic [1:0]        awlock;

    logic              rvalid;
    logic              rready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;

    logic                wvalid;
    logic                wready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;

    logic       bvalid;
    logic       bready;
    logic [1:0] bresp;

    modport master (
        output arvalid, araddr, arburst, arlen, arsize, arcache, arprot, arlock,
        input  arready,
        output awvalid, awaddr, awburst, awlen, awsize, awcache, awprot, awlock,
        input  awready,
        input  rvalid, rdata, rresp, rlast,
        output rready,
        output wvalid, wdata, wstrb, wlast,
        input  wready,
        input  bvalid, bresp,
        output bready
    );

    modport slave (
        input  arvalid, araddr, arburst, arlen, arsize, arcache, arprot, arlock,
        output arready,
        input  awvalid, awaddr, awburst, awlen, awsize, awcache, awprot, awlock,
        output awready,
        output rvalid, rdata, rresp, rlast,
        input  rready,
        input  wvalid, wdata, wstrb, wlast,
        output wready,
        output bvalid, bresp,
        input  bready
    );
endinterface

// File: rtl/expl_axi_sram_slave.sv
// Single-outstanding AXI responder backed by a word-addressed register-array SRAM.
//   state | meaning
//   IDLE  | waiting for AW (preferred) or AR
//   RD    | presenting read beats, one per cycle while rready
//   WR    | accepting write beats until len+1 have been taken
//   WRESP | presenting the write response
module expl_axi_sram_slave #(
    parameter int              ADDR_W    = 32,
    parameter int              DATA_W    = 32,
    parameter int              MEM_AW    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h1000_0000
) (
    input logic        clk,
    input logic        rst_n,
    expl_axi_if.slave  axi
);
    localparam int IDX_W = ADDR_W - 2;

    typedef enum logic [1:0] {IDLE, RD, WR, WRESP} state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q;
    logic [3:0]        len_q;
    logic [3:0]        cnt_q;
    logic [1:0]        burst_q;
    logic [2:0]        size_q;
    logic              below_q;
    logic              err_q;

    logic [DATA_W-1:0] mem [2**MEM_AW];

    logic              aw_hs, ar_hs, r_hs, w_hs, b_hs;
    logic [ADDR_W-1:0] start_addr, offset;
    logic              beat_err, last_beat;
    logic [MEM_AW-1:0] mem_idx;

    assign aw_hs = axi.awvalid && axi.awready;
    assign ar_hs = axi.arvalid && axi.arready;
    assign r_hs  = axi.rvalid  && axi.rready;
    assign w_hs  = axi.wvalid  && axi.wready;
    assign b_hs  = axi.bvalid  && axi.bready;

    assign start_addr = aw_hs ? axi.awaddr : axi.araddr;
    assign offset     = start_addr - BASE_ADDR;

    // Any index bit at or above MEM_AW means the beat falls past the array.
    assign beat_err  = (size_q != 3'd2) || (burst_q == 2'b10) ||
                       (|idx_q[IDX_W-1:MEM_AW]) || below_q;
    assign last_beat = (cnt_q == len_q);
    assign mem_idx   = idx_q[MEM_AW-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        axi.awready = 1'b0;
        axi.arready = 1'b0;
        axi.rvalid  = 1'b0;
        axi.rdata   = '0;
        axi.rresp   = 2'b00;
        axi.rlast   = 1'b0;
        axi.wready  = 1'b0;
        axi.bvalid  = 1'b0;
        axi.bresp   = 2'b00;
        case (state_q)
            IDLE: begin
                // Gated by rst_n so the ready outputs read 0 while reset is held.
                axi.awready = rst_n;
                axi.arready = rst_n && !axi.awvalid;
                if (aw_hs)      state_d = WR;
                else if (ar_hs) state_d = RD;
            end
            RD: begin
                axi.rvalid = 1'b1;
                axi.rdata  = beat_err ? '0 : mem[mem_idx];
                axi.rresp  = beat_err ? 2'b10 : 2'b00;
                axi.rlast  = last_beat;
                if (r_hs && last_beat) state_d = IDLE;
            end
            WR: begin
                axi.wready = 1'b1;
                if (w_hs && last_beat) state_d = WRESP;
            end
            WRESP: begin
                axi.bvalid = 1'b1;
                axi.bresp  = err_q ? 2'b10 : 2'b00;
                if (b_hs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q   <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            burst_q <= '0;
            size_q  <= '0;
            below_q <= 1'b0;
            err_q   <= 1'b0;
        end else if (aw_hs || ar_hs) begin
            idx_q   <= offset[ADDR_W-1:2];
            len_q   <= aw_hs ? axi.awlen   : axi.arlen;
            burst_q <= aw_hs ? axi.awburst : axi.arburst;
            size_q  <= aw_hs ? axi.awsize  : axi.arsize;
            below_q <= (start_addr < BASE_ADDR);
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else if (r_hs || w_hs) begin
            if (!last_beat) begin
                cnt_q <= cnt_q + 4'd1;
                if (burst_q != 2'b00) idx_q <= idx_q + IDX_W'(1);
            end
            if (w_hs && (beat_err || (axi.wlast != last_beat))) err_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_hs && !beat_err) begin
            for (int b = 0; b < DATA_W/8; b++) begin
                if (axi.wstrb[b]) mem[mem_idx][8*b +: 8] <= axi.wdata[8*b +: 8];
            end
        end
    end

    logic unused_ign;
    assign unused_ign = ^{axi.arcache, axi.arprot, axi.arlock,
                          axi.awcache, axi.awprot, axi.awlock, offset[1:0]};
endmodule

// File: tb/tb_expl_axi_sram_slave.sv
// Directed bench for expl_axi_sram_slave with queue-based response scoreboard.
module tb_expl_axi_sram_slave;
    localparam logic [31:0] B = 32'h1000_0000;
    localparam logic [1:0]  FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    expl_axi_if #(.ADDR_W(32), .DATA_W(32)) axi ();

    expl_axi_sram_slave dut (.clk(clk), .rst_n(rst_n), .axi(axi));

    typedef struct packed {logic [31:0] d; logic [1:0] resp; logic last;} rbeat_t;
    typedef struct packed {logic [31:0] d; logic [3:0] s; logic l;} wbeat_t;

    rbeat_t     exp_r[$];
    logic [1:0] exp_b[$];
    wbeat_t     wq[$];

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic tmo(input string nm);
        n_total++;
        $display("FAIL %s: timed out waiting for DUT", nm);
    endtask

    task automatic er(input logic [31:0] d, input logic [1:0] resp, input logic last);
        exp_r.push_back('{d: d, resp: resp, last: last});
    endtask

    task automatic wb(input logic [31:0] d, input logic [3:0] s, input logic l);
        wq.push_back('{d: d, s: s, l: l});
    endtask

    // Scoreboard monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (axi.rvalid) begin
                if (exp_r.size() == 0) begin
                    n_total++;
                    $display("FAIL r_unexpected: got rdata %h with no beat expected", axi.rdata);
                end else if (axi.rready) begin
                    rbeat_t e;
                    e = exp_r.pop_front();
                    chk("rdata", axi.rdata, e.d);
                    chk("rresp", 32'(axi.rresp), 32'(e.resp));
                    chk("rlast", 32'(axi.rlast), 32'(e.last));
                end else begin
                    chk("rdata_stall", axi.rdata, exp_r[0].d);
                    chk("rlast_stall", 32'(axi.rlast), 32'(exp_r[0].last));
                end
            end
            if (axi.bvalid && axi.bready) begin
                if (exp_b.size() == 0) begin
                    n_total++;
                    $display("FAIL b_unexpected: got bresp %h with none expected", axi.bresp);
                end else begin
                    chk("bresp", 32'(axi.bresp), 32'(exp_b.pop_front()));
                end
            end
        end
    end

    task automatic do_write(input logic [31:0] addr, input logic [3:0] len,
                            input logic [2:0] size, input logic [1:0] burst,
                            input logic [1:0] bresp);
        int n;
        exp_b.push_back(bresp);
        @(posedge clk); #1;
        axi.awaddr = addr; axi.awlen = len; axi.awsize = size; axi.awburst = burst;
        axi.awvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!axi.awready && n < 100);
        if (!axi.awready) tmo("awready");
        @(posedge clk); #1;
        axi.awvalid = 1'b0;
        while (wq.size() != 0) begin
            wbeat_t w;
            w = wq.pop_front();
            axi.wvalid = 1'b1; axi.wdata = w.d; axi.wstrb = w.s; axi.wlast = w.l;
            n = 0;
            do begin @(negedge clk); n++; end while (!axi.wready && n < 100);
            if (!axi.wready) tmo("wready");
            @(posedge clk); #1;
        end
        axi.wvalid = 1'b0; axi.wlast = 1'b0;
        @(negedge clk);
        chk("bvalid_latency", 32'(axi.bvalid), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bvalid_drop", 32'(axi.bvalid), 32'd0);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [3:0] len,
                           input logic [2:0] size, input logic [1:0] burst,
                           input bit toggle);
        int n;
        axi.rready = 1'b1;
        @(posedge clk); #1;
        axi.araddr = addr; axi.arlen = len; axi.arsize = size; axi.arburst = burst;
        axi.arvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!axi.arready && n < 100);
        if (!axi.arready) tmo("arready");
        @(posedge clk); #1;
        axi.arvalid = 1'b0;
        @(negedge clk);
        chk("rvalid_latency", 32'(axi.rvalid), 32'd1);
        #1;
        n = 0;
        while (exp_r.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            if (toggle) axi.rready = ~axi.rready;
            @(negedge clk); #1;
            n++;
        end
        if (exp_r.size() != 0) begin
            tmo("read_beats");
            exp_r.delete();
        end
        axi.rready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rvalid_drop", 32'(axi.rvalid), 32'd0);
    endtask

    initial begin
        int n;
        axi.arvalid = 0; axi.araddr = '0; axi.arburst = INCR; axi.arlen = '0; axi.arsize = 3'd2;
        axi.arcache = '0; axi.arprot = '0; axi.arlock = '0;
        axi.awvalid = 0; axi.awaddr = '0; axi.awburst = INCR; axi.awlen = '0; axi.awsize = 3'd2;
        axi.awcache = '0; axi.awprot = '0; axi.awlock = '0;
        axi.wvalid = 0; axi.wdata = '0; axi.wstrb = '0; axi.wlast = 0;
        axi.rready = 1; axi.bready = 1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_arready", 32'(axi.arready), 32'd0);
        chk("rst_awready", 32'(axi.awready), 32'd0);
        chk("rst_rvalid",  32'(axi.rvalid),  32'd0);
        chk("rst_rlast",   32'(axi.rlast),   32'd0);
        chk("rst_wready",  32'(axi.wready),  32'd0);
        chk("rst_bvalid",  32'(axi.bvalid),  32'd0);
        chk("rst_rdata",   axi.rdata,        32'd0);
        chk("rst_rresp",   32'(axi.rresp),   32'd0);
        chk("rst_bresp",   32'(axi.bresp),   32'd0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("idle_awready", 32'(axi.awready), 32'd1);
        chk("idle_arready", 32'(axi.arready), 32'd1);

        // Single write then read back
        wb(32'hDEADBEEF, 4'hF, 1);
        do_write(B + 32'h10, 0, 3'd2, INCR, 2'b00);
        er(32'hDEADBEEF, 2'b00, 1);
        do_read(B + 32'h10, 0, 3'd2, INCR, 0);

        // Burst write, partial-strobe overwrite, then reads (plain and stalled)
        wb(32'h11111111, 4'hF, 0); wb(32'h22222222, 4'hF, 0);
        wb(32'h33333333, 4'hF, 0); wb(32'h44444444, 4'hF, 1);
        do_write(B, 3, 3'd2, INCR, 2'b00);
        wb(32'hAABBCCDD, 4'h3, 1);
        do_write(B + 32'h4, 0, 3'd2, INCR, 2'b00);
        for (int k = 0; k < 2; k++) begin
            er(32'h11111111, 2'b00, 0); er(32'h2222CCDD, 2'b00, 0);
            er(32'h33333333, 2'b00, 0); er(32'h44444444, 2'b00, 1);
            do_read(B, 3, 3'd2, INCR, k == 1);
        end

        // FIXED burst repeats the same word
        er(32'h33333333, 2'b00, 0); er(32'h33333333, 2'b00, 1);
        do_read(B + 32'h8, 1, 3'd2, FIXED, 0);

        // Last word in range
        wb(32'hCAFEF00D, 4'hF, 1);
        do_write(B + 32'h3FC, 0, 3'd2, INCR, 2'b00);
        er(32'hCAFEF00D, 2'b00, 1);
        do_read(B + 32'h3FC, 0, 3'd2, INCR, 0);

        // Simultaneous AR and AW: write goes first
        exp_b.push_back(2'b00);
        er(32'h5A5A0001, 2'b00, 1);
        @(posedge clk); #1;
        axi.awaddr = B + 32'h20; axi.awlen = 0; axi.awsize = 3'd2; axi.awburst = INCR;
        axi.araddr = B + 32'h20; axi.arlen = 0; axi.arsize = 3'd2; axi.arburst = INCR;
        axi.awvalid = 1; axi.arvalid = 1;
        @(negedge clk);
        chk("both_awready", 32'(axi.awready), 32'd1);
        chk("both_arready", 32'(axi.arready), 32'd0);
        @(posedge clk); #1;
        axi.awvalid = 0;
        axi.wvalid = 1; axi.wdata = 32'h5A5A0001; axi.wstrb = 4'hF; axi.wlast = 1;
        @(negedge clk);
        chk("wr_arready", 32'(axi.arready), 32'd0);
        chk("wr_wready",  32'(axi.wready),  32'd1);
        @(posedge clk); #1;
        axi.wvalid = 0; axi.wlast = 0;
        @(negedge clk);
        chk("wresp_bvalid",  32'(axi.bvalid),  32'd1);
        chk("wresp_arready", 32'(axi.arready), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("post_b_arready", 32'(axi.arready), 32'd1);
        @(posedge clk); #1;
        axi.arvalid = 0;
        n = 0;
        while (exp_r.size() != 0 && n < 50) begin @(negedge clk); #1; n++; end
        if (exp_r.size() != 0) begin tmo("both_read"); exp_r.delete(); end

        // Error cases
        er(32'h0, 2'b10, 1);
        do_read(B + 32'h400, 0, 3'd2, INCR, 0);
        er(32'h0, 2'b10, 1);
        do_read(B - 32'h4, 0, 3'd2, INCR, 0);
        wb(32'h12345678, 4'hF, 1);
        do_write(B + 32'h10, 0, 3'd1, INCR, 2'b10);
        er(32'hDEADBEEF, 2'b00, 1);
        do_read(B + 32'h10, 0, 3'd2, INCR, 0);
        er(32'h0, 2'b10, 0); er(32'h0, 2'b10, 1);
        do_read(B, 1, 3'd2, WRAP, 0);

        // Misplaced wlast: all beats taken and written, response is SLVERR
        wb(32'hA0A0A0A0, 4'hF, 0); wb(32'hA1A1A1A1, 4'hF, 1);
        wb(32'hA2A2A2A2, 4'hF, 0); wb(32'hA3A3A3A3, 4'hF, 0);
        do_write(B + 32'h30, 3, 3'd2, INCR, 2'b10);
        er(32'hA0A0A0A0, 2'b00, 0); er(32'hA1A1A1A1, 2'b00, 0);
        er(32'hA2A2A2A2, 2'b00, 0); er(32'hA3A3A3A3, 2'b00, 1);
        do_read(B + 32'h30, 3, 3'd2, INCR, 0);

        // Reset during beat 2 of a 4-beat read
        er(32'h11111111, 2'b00, 0); er(32'h2222CCDD, 2'b00, 0);
        er(32'h33333333, 2'b00, 0); er(32'h44444444, 2'b00, 1);
        axi.rready = 1;
        @(posedge clk); #1;
        axi.araddr = B; axi.arlen = 3; axi.arsize = 3'd2; axi.arburst = INCR;
        axi.arvalid = 1;
        n = 0;
        do begin @(negedge clk); n++; end while (!axi.arready && n < 100);
        if (!axi.arready) tmo("rst_arready_wait");
        @(posedge clk); #1;
        axi.arvalid = 0;
        @(negedge clk);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_rvalid",  32'(axi.rvalid),  32'd0);
        chk("midrst_rlast",   32'(axi.rlast),   32'd0);
        chk("midrst_rdata",   axi.rdata,        32'd0);
        chk("midrst_arready", 32'(axi.arready), 32'd0);
        exp_r.delete();
        @(negedge clk); #2;
        rst_n = 1'b1;
        @(negedge clk);
        chk("postrst_arready", 32'(axi.arready), 32'd1);
        er(32'hDEADBEEF, 2'b00, 1);
        do_read(B + 32'h10, 0, 3'd2, INCR, 0);
        er(32'h11111111, 2'b00, 0); er(32'h2222CCDD, 2'b00, 0);
        er(32'h33333333, 2'b00, 0); er(32'h44444444, 2'b00, 1);
        do_read(B, 3, 3'd2, INCR, 0);

        repeat (3) @(posedge clk);
        chk("pending_r", 32'(exp_r.size()), 32'd0);
        chk("pending_b", 32'(exp_b.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d passed so far", n_pass, n_total);
        $fatal(1);
    end
endmodule

// File: doc/expl_axi_sram_slave.md
Name: expl_axi_sram_slave

Overview:
- AXI responder that terminates the SoC's expl_axi master port.
- Backs the port with a word-addressed register-array SRAM and serves one transaction at a time.
- Supports single-beat and burst read/write; reports SLVERR for unsupported or out-of-range accesses.
- Sits in the FPGA system top, outside e203_soc_top, in the 16 MHz core clock domain.

Parameters:
ADDR_W, 32, AXI address width (matches E203_ADDR_SIZE)
DATA_W, 32, AXI data width (matches E203_XLEN); only 32 is supported
MEM_AW, 8, word-index width; memory depth is 2**MEM_AW words
BASE_ADDR, 32'h1000_0000, byte address of word 0

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
arvalid/arready  in/out  1/1  read address handshake
araddr  in  ADDR_W  read start byte address
arburst  in  2  00 FIXED, 01 INCR, 10 WRAP
arlen  in  4  beats minus 1
arsize  in  3  bytes per beat, log2
arcache, arprot, arlock  in  4/3/2  ignored
awvalid/awready  in/out  1/1  write address handshake
awaddr, awburst, awlen, awsize  in  ADDR_W/2/4/3  same meaning as the AR fields
awcache, awprot, awlock  in  4/3/2  ignored
rvalid/rready  out/in  1/1  read data handshake
rdata  out  DATA_W  read data
rresp  out  2  00 OKAY, 10 SLVERR
rlast  out  1  final read beat
wvalid/wready  in/out  1/1  write data handshake
wdata  in  DATA_W  write data
wstrb  in  DATA_W/8  byte enables
wlast  in  1  final write beat from master
bvalid/bready  out/in  1/1  write response handshake
bresp  out  2  00 OKAY, 10 SLVERR

Behaviour:
- Clock and reset: single clock clk. rst_n is asynchronous and active-low.
- Reset values: arready, awready, rvalid, rlast, wready, bvalid all 0; rdata 0; rresp and bresp 00; FSM in IDLE. Memory contents are not reset.
- FSM states: IDLE, RD, WR, WRESP.
- IDLE handshakes:
  - awready = (state==IDLE).
  - arready = (state==IDLE) && !awvalid, so write wins when both are valid in the same cycle.
  - AW handshake latches addr/len/burst/size, clears the beat counter and error flag, and moves to WR.
  - AR handshake latches the same fields and moves to RD.
- Beat address:
  - Word index = (addr - BASE_ADDR) >> 2.
  - INCR: index advances by 1 per beat.
  - FIXED: index is held for all beats.
  - WRAP: treated as INCR addressing but every beat is flagged as an error.
- Per-beat error condition: size != 2, or burst == WRAP, or index >= 2**MEM_AW, or addr < BASE_ADDR.
  - Error read beat: rdata = 0, rresp = 10.
  - Error write beat: data is discarded and the sticky error flag is set.
- RD state:
  - rvalid = 1 from the cycle after the AR handshake.
  - rdata, rresp and rlast are stable while rvalid && !rready.
  - On rvalid && rready: the next beat is presented in the following cycle, sustaining 1 beat/cycle.
  - rlast = 1 when beat counter == latched len.
  - Handshake on the rlast beat: rvalid drops in the next cycle, FSM returns to IDLE.
- WR state:
  - wready = 1.
  - On wvalid && wready: bytes with wstrb=1 are written at the current index; the beat counter increments.
  - wlast == 1 on a non-final beat, or wlast == 0 on the final beat, sets the error flag.
  - After beat len+1 is accepted, wready drops and the FSM goes to WRESP. The burst length is set by the beat count only.
- WRESP state:
  - bvalid = 1; bresp = 10 if the error flag is set, else 00.
  - On bvalid && bready: bvalid drops in the next cycle, FSM returns to IDLE.
- Latency and throughput: AR handshake to first rvalid is 1 cycle. Last W beat to bvalid is 1 cycle. A new AR/AW is accepted no earlier than the cycle after the final R/B handshake.
- Counters: the beat counter is 4 bits, so the maximum burst is 16 beats; no wrap beyond len.
- Reset mid-operation: all outputs return to reset values immediately. Memory words written by earlier beats are retained.

Test Plan:
- Single write then read: AW addr=BASE+0x10, len=0, size=2, INCR; W data=0xDEADBEEF, strb=F, wlast=1 -> bresp=00. Then AR on the same address -> rdata=0xDEADBEEF, rresp=00, rlast=1, first rvalid 1 cycle after AR handshake.
- Burst with strobes: write INCR len=3 at BASE, data 0x11111111..0x44444444, strb=F; then 1-beat write at BASE+4, data 0xAABBCCDD, strb=0x3; then read INCR len=3 -> 0x11111111, 0x2222CCDD, 0x33333333, 0x44444444 with rlast on beat 4 only. Repeat the read with rready toggling 1/0 -> data held stable while stalled; same sequence delivered.
- Simultaneous AR and AW in IDLE -> awready=1, arready=0; write completes (bvalid) before the read is accepted; the read returns the newly written data.
- Error cases:
  - Read at BASE + 4*2**MEM_AW -> rdata=0, rresp=10.
  - Write with size=1 -> bresp=10 and memory unchanged.
  - WRAP read len=1 -> both beats rresp=10.
- Write len=3 with wlast asserted on beat 2 -> all 4 beats accepted, bresp=10.
- Assert rst_n low during beat 2 of a 4-beat read -> rvalid=0 and the FSM is in IDLE in the same cycle. After release, a new AR is accepted, and data written before the reset is still readable.
